// File: rtl/pe_mac_bank_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the multiply-accumulate processing element:
//   - default width constants (INT_BITS.FRAC_BITS operands, bank count, guards)
//   - width derivation functions for the product, accumulator and bank select
//   - pe_beat_t, the pipeline beat at default widths, for array-level code
//   - sat_signed, a generic signed clamp, also used by the compute array
// No ports; pure package.
// -----------------------------------------------------------------------------
package pe_pkg;

    localparam int DEF_INT_BITS   = 7;
    localparam int DEF_FRAC_BITS  = 9;
    localparam int DEF_ACC_DEPTH  = 8;
    localparam int DEF_GUARD_BITS = 4;

    // Full-precision product width for two W-bit signed operands.
    function automatic int calc_p(input int w);
        return 2 * w;
    endfunction

    // Accumulator width: product width plus guard MSBs.
    function automatic int calc_a(input int w, input int guard);
        return 2 * w + guard;
    endfunction

    // Bank select width.
    function automatic int calc_s(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEF_W = DEF_INT_BITS + DEF_FRAC_BITS;
    localparam int DEF_P = calc_p(DEF_W);
    localparam int DEF_S = calc_s(DEF_ACC_DEPTH);

    typedef struct packed {
        logic signed [DEF_P-1:0] product;
        logic [DEF_S-1:0]        sel;
        logic                    clear;
        logic                    last;
    } pe_beat_t;

    // Clamp a sign-extended value to the signed range of a w-bit word.
    // Callers keep w <= 64.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/pe_mac_bank_if.sv
// -----------------------------------------------------------------------------
// pe_mac_bank_if
// Input beat channel and result channel of the MAC processing element.
//   in_valid/in_ready, a, b, acc_sel, acc_clear, acc_last : operand beat
//   out_valid/out_ready, out_data, out_sel, out_sat      : rounded result
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holds valid and its payload stable until that
// edge; a consumer may change ready freely. in_ready is a combinational
// function of out_ready (the PE only stalls while a result is refused).
// Modports: master drives beats and consumes results, slave is the PE.
// -----------------------------------------------------------------------------
interface pe_mac_bank_if #(
    parameter int W = pe_pkg::DEF_W,
    parameter int S = pe_pkg::DEF_S
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic [S-1:0]        acc_sel;
    logic                acc_clear;
    logic                acc_last;

    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic [S-1:0]        out_sel;
    logic                out_sat;

    modport master (
        output in_valid, a, b, acc_sel, acc_clear, acc_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_sat
    );

    modport slave (
        input  in_valid, a, b, acc_sel, acc_clear, acc_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_sat
    );
endinterface

// File: rtl/pe_mac_bank_round_sat.sv
// -----------------------------------------------------------------------------
// pe_round_sat
// Combinational output stage: rounds an A-bit accumulator value (FRAC_BITS
// extra fraction bits relative to the result) half-up, then saturates it to a
// signed W-bit word.
//   i_acc  in  A  signed accumulator value (already clamped to A bits)
//   o_data out W  rounded, saturated result
//   o_sat  out 1  set when the saturation changed the rounded value
// -----------------------------------------------------------------------------
module pe_round_sat
    import pe_pkg::*;
#(
    parameter int A         = 36,
    parameter int W         = 16,
    parameter int FRAC_BITS = 9
) (
    input  logic signed [A-1:0] i_acc,
    output logic signed [W-1:0] o_data,
    output logic                o_sat
);
    localparam logic signed [A:0] HALF = {{A{1'b0}}, 1'b1} <<< (FRAC_BITS - 1);

    logic signed [A:0]  w_rnd;
    logic signed [A:0]  w_shift;
    logic signed [63:0] w_wide;
    logic signed [63:0] w_clamp;

    // One extra MSB so adding the half-LSB to the most positive value
    // cannot wrap.
    assign w_rnd   = {i_acc[A-1], i_acc} + HALF;
    assign w_shift = w_rnd >>> FRAC_BITS;
    assign w_wide  = 64'(w_shift);
    assign w_clamp = sat_signed(w_wide, W);

    assign o_data = w_clamp[W-1:0];
    assign o_sat  = (w_clamp != w_wide);
endmodule

// File: rtl/pe_mac_bank.sv
// -----------------------------------------------------------------------------
// pe_mac_bank
// Fixed-point multiply-accumulate processing element with ACC_DEPTH
// independent accumulator banks.
//   clk    in  clock, rising edge
//   rst_n  in  synchronous active-low reset
//   pe_bus slave modport of pe_mac_bank_if (operand beats in, results out)
// Pipeline: S0 registers the full-precision product with its tags into S1;
// S1 adds it to the selected bank (clamped to A bits, sticky overflow per
// bank) and, on a last beat, loads the rounded result into the output
// register. A refused result freezes the whole pipeline.
// -----------------------------------------------------------------------------
module pe_mac_bank
    import pe_pkg::*;
#(
    parameter int INT_BITS   = DEF_INT_BITS,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_DEPTH  = DEF_ACC_DEPTH,
    parameter int GUARD_BITS = DEF_GUARD_BITS
) (
    input logic          clk,
    input logic          rst_n,
    pe_mac_bank_if.slave pe_bus
);
    localparam int W = INT_BITS + FRAC_BITS;
    localparam int P = calc_p(W);
    localparam int A = calc_a(W, GUARD_BITS);
    localparam int S = calc_s(ACC_DEPTH);

    typedef struct packed {
        logic signed [P-1:0] product;
        logic [S-1:0]        sel;
        logic                clear;
        logic                last;
    } s1_beat_t;

    logic                w_stall;
    logic signed [P-1:0] w_product;
    logic [S-1:0]        w_sel_in;
    s1_beat_t            w_beat;

    logic                r_s1_valid;
    s1_beat_t            r_s1;

    logic [A-1:0]        r_bank [ACC_DEPTH];
    logic [ACC_DEPTH-1:0] r_ovf;

    logic [A-1:0]        w_base;
    logic [A:0]          w_sum;
    logic                w_ovf;
    logic [A-1:0]        w_sum_clamped;
    logic                w_ovf_next;
    logic [W-1:0]        w_rs_data;
    logic                w_rs_sat;

    logic                r_out_valid;
    logic [W-1:0]        r_out_data;
    logic [S-1:0]        r_out_sel;
    logic                r_out_sat;

    // A result held but refused freezes S1, the banks and the output register.
    assign w_stall         = r_out_valid && !pe_bus.out_ready;
    assign pe_bus.in_ready = !w_stall;

    assign w_product = pe_bus.a * pe_bus.b;
    // Out-of-range bank numbers fold onto bank 0.
    assign w_sel_in  = (32'(pe_bus.acc_sel) < ACC_DEPTH) ? pe_bus.acc_sel : '0;
    assign w_beat    = '{product: w_product, sel: w_sel_in,
                         clear: pe_bus.acc_clear, last: pe_bus.acc_last};

    // The bank is written on the same edge that moves the next beat into S1,
    // so a back-to-back beat to the same bank reads the fresh value directly.
    assign w_base = r_s1.clear ? '0 : r_bank[r_s1.sel];
    assign w_sum  = {w_base[A-1], w_base}
                  + {{(A + 1 - P){r_s1.product[P-1]}}, r_s1.product};
    // The two top bits differ exactly when the A+1-bit sum left the A-bit range.
    assign w_ovf         = w_sum[A] ^ w_sum[A-1];
    assign w_sum_clamped = w_ovf ? {w_sum[A], {(A - 1){!w_sum[A]}}} : w_sum[A-1:0];
    assign w_ovf_next    = (!r_s1.clear && r_ovf[r_s1.sel]) || w_ovf;

    pe_round_sat #(
        .A         (A),
        .W         (W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .i_acc  (w_sum_clamped),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_ovf       <= '0;
            for (int i = 0; i < ACC_DEPTH; i++) begin
                r_bank[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_sat   <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= pe_bus.in_valid;
            if (pe_bus.in_valid) begin
                r_s1 <= w_beat;
            end

            if (r_s1_valid) begin
                r_bank[r_s1.sel] <= w_sum_clamped;
                r_ovf[r_s1.sel]  <= w_ovf_next;
            end

            // Not stalled means any held result is being taken this cycle,
            // so the register either reloads or empties.
            if (r_s1_valid && r_s1.last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rs_data;
                r_out_sel   <= r_s1.sel;
                r_out_sat   <= w_rs_sat || w_ovf_next;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign pe_bus.out_valid = r_out_valid;
    assign pe_bus.out_data  = r_out_data;
    assign pe_bus.out_sel   = r_out_sel;
    assign pe_bus.out_sat   = r_out_sat;
endmodule

// File: doc/pe_mac_bank.md
# pe_mac_bank

Parametrised fixed-point multiply-accumulate processing element with `ACC_DEPTH` independent accumulator banks, valid/ready handshakes on input and output, and a round-and-saturate output stage. It replaces the single-bank PE in the compute array. It accepts one operand pair per cycle, accumulates the product into a selected bank at full precision, and emits a rounded `INT_BITS.FRAC_BITS` result when a beat is tagged `last`.

## Interface
- `INT_BITS`, 7, integer bits of operands and result, sign included.
- `FRAC_BITS`, 9, fraction bits, ≥1.
- `ACC_DEPTH`, 8, number of accumulator banks, ≥2.
- `GUARD_BITS`, 4, extra accumulator MSBs above the product width.
- Derived widths: `W = INT_BITS+FRAC_BITS`, `P = 2W`, `A = P+GUARD_BITS`, `S = $clog2(ACC_DEPTH)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `a`, `b`  in  W each  signed two's-complement operands.
- `acc_sel`  in  S  target bank; values ≥ `ACC_DEPTH` are treated as bank 0.
- `acc_clear`  in  1  bank starts from 0 instead of its stored value; clears the bank's sticky overflow flag.
- `acc_last`  in  1  emit the bank result after this beat.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_data`  out  W  rounded, saturated result.
- `out_sel`  out  S  bank that produced `out_data`.
- `out_sat`  out  1  result saturated, or the bank overflowed since its last clear.

## Operation
- **Stall rule.** `stall = out_valid && !out_ready`; `in_ready = !stall`. While stalled, nothing changes: S1, the banks and the output register all hold.
- **S0 (accept).** On handshake, register the signed `P`-bit product `a*b`, together with `acc_sel`, `acc_clear` and `acc_last`, into S1. S1 becomes valid.
- **S1 (accumulate).**
  - `base = acc_clear ? 0 : bank[sel]`.
  - `sum = base + sext(product)`, computed at `A+1` bits.
  - If `sum` exceeds the signed `A`-bit range, it clamps to the range limit and `ovf[sel]` is set.
  - Write `bank[sel]`.
  - `ovf[sel]` is cleared by `acc_clear`, then OR-ed with the new overflow.
- **Read-after-write.** Back-to-back beats to the same bank need no bubble; the S1 read sees the previous write.
- **Round and saturate** (S1, when `acc_last`):
  - `r = (sum_clamped + 2^(FRAC_BITS-1)) >>> FRAC_BITS` (round half up, arithmetic shift).
  - Saturate `r` to [−2^(W−1), 2^(W−1)−1].
  - Load `out_data`, `out_sel` and `out_sat = sat_r | ovf_next[sel]` into the output register; set `out_valid`.
- **Output register.**
  - A handshake with no new `last` arriving clears `out_valid`.
  - A handshake and a new `last` in the same cycle reload the register; `out_valid` stays 1.
- **Bank after `last`.** The bank keeps its value after `last`. The next beat to that bank must carry `acc_clear` to start a fresh sum.
- **Single-term result.** `acc_clear && acc_last` on the same beat gives the rounded single product.
- **Reset.**
  - All banks = 0, all `ovf` = 0, S1 invalid.
  - `out_valid = 0`, `out_data = 0`, `out_sel = 0`, `out_sat = 0`.
  - `in_ready` = 1 from the first cycle after reset.
  - Reset mid-accumulation discards all partial sums and any pending output.

## Timing
- **Latency.** A beat accepted in cycle t with `last` gives `out_valid` in cycle t+2.
- **Throughput.** One beat per cycle while `out_ready` is held high.
- **Backpressure.** `in_ready` falls in the cycle `out_valid && !out_ready` holds. One S1 beat may be frozen in flight. Both resume in the cycle after `out_ready` rises.
- **Combinational paths.**
  - Critical path: bank read → adder → clamp → round → saturate → output register.
  - `in_ready` depends combinationally on `out_ready`.

## Structure
- Package `pe_pkg` holds:
  - default width constants;
  - the width-derivation functions (`P`, `A`, `S`);
  - the `pe_beat_t` struct (`product`, `sel`, `clear`, `last`);
  - the `sat_signed` clamp function, reused by the array.
- Sub-module `pe_round_sat`, purely combinational: `A`-bit in → `W`-bit out plus sat flag, parametrised on `A`, `W` and `FRAC_BITS`.
- The banks are a flop array, since `ACC_DEPTH` is small; no RAM macro.

## Test plan
All values use the defaults, where 1.0 = 0x0200.
- **Basic accumulate.** 4 beats to bank 3, each `a=0x0200`, `b=0x0300`; `clear` on beat 1, `last` on beat 4, `out_ready=1` → `out_data=0x0C00`, `out_sel=3`, `out_sat=0`, two cycles after beat 4.
- **Rounding.**
  - `a=0x0001`, `b=0x0100`, `clear+last` → `0x0001` (half rounds up).
  - `a=0xFFFF`, `b=0x0100`, `clear+last` → `0x0000`.
  - `a=0xFE00`, `b=0x0300` → `0xFD00`.
- **Saturation.** `a=b=0x7FFF`, `clear+last` → `0x7FFF`, `out_sat=1`. Then `a=0x8000`, `b=0x7FFF` → `0x8000`, `out_sat=1`.
- **Interleaving.** Alternate banks 0 and 1 each cycle with `a=0x0200`, `b=0x0200`, 3 beats each, `last` on the third beat → two consecutive outputs, 0x0600 from bank 0 then bank 1. Back-to-back same-bank beats accumulate correctly.
- **Backpressure.** Hold `out_ready=0` with a result pending and stream more beats:
  - `in_ready` drops;
  - the frozen `last` beat is not lost;
  - after `out_ready=1`, both results appear in order with values unchanged.
- **Reset mid-operation.** Assert `rst_n=0` after 2 of 4 beats, then run a fresh 1-beat sum without `clear` → the result reflects the zeroed bank; `out_valid=0` during reset.
